// File: rtl/sram_arb_pkg.sv
// Shared constants and the read-return tag type for the SRAM port arbiter.
// Optional build macro used by this block: SRAM_ARB_WR_FWD_EN.
package sram_arb_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int PORT_ID_W      = $clog2(DEF_NUM_PORTS);

    // One stage of the read-return pipeline: which requester owns the data.
    typedef struct packed {
        logic                     valid;
        logic [DEF_NUM_PORTS-1:0] port_oh;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, port_oh: '0};

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake and SRAM-side command bundle for sram_port_arbiter.
// master = requesters plus SRAM macro, slave = the arbiter.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_PORTS-1:0]            wr_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_PORTS-1:0]            wr_gnt;
    logic [NUM_PORTS-1:0]            rd_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_PORTS-1:0]            rd_gnt;
    logic [NUM_PORTS-1:0]            rd_vld;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic                            sram_wr_en;
    logic [ADDR_WIDTH-1:0]           sram_wr_addr;
    logic [DATA_WIDTH-1:0]           sram_din;
    logic                            sram_rd_en;
    logic [ADDR_WIDTH-1:0]           sram_rd_addr;
    logic [DATA_WIDTH-1:0]           sram_dout;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        input  wr_gnt, rd_gnt, rd_vld, rd_data,
        input  sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        output wr_gnt, rd_gnt, rd_vld, rd_data,
        output sram_wr_en, sram_wr_addr, sram_din, sram_rd_en, sram_rd_addr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner; holds it when idle.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        gnt   = '0;
        ptr_d = ptr_q;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel = PW'((int'(ptr_q) + i) % N);
            if (req[sel] && !found) begin
                gnt[sel] = 1'b1;
                ptr_d    = PW'((int'(sel) + 1) % N);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one packet-buffer SRAM between NUM_PORTS requesters with independent
// round-robin write/read channels; define SRAM_ARB_WR_FWD_EN for same-cycle write forwarding.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    sram_port_arbiter_if.slave bus
);

    logic [NUM_PORTS-1:0]  wr_gnt;
    logic [NUM_PORTS-1:0]  rd_gnt;
    logic [ADDR_WIDTH-1:0] wr_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;
    logic [ADDR_WIDTH-1:0] rd_addr_sel;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    rd_tag_t               tag_s1;
    rd_tag_t               tag_s2;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] ret_data;

    rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.wr_req),
        .gnt (wr_gnt)
    );

    rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.rd_req),
        .gnt (rd_gnt)
    );

    // Grants are one-hot, so the winner's fields can be OR-selected.
    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_gnt[i]) begin
                wr_addr_sel = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt[i]) rd_addr_sel = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            din_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tag_s1    <= RD_TAG_IDLE;
            tag_s2    <= RD_TAG_IDLE;
            rd_data_q <= '0;
        end else begin
            wr_en_q   <= |wr_gnt;
            wr_addr_q <= wr_addr_sel;
            din_q     <= wr_data_sel;
            rd_en_q   <= |rd_gnt;
            rd_addr_q <= rd_addr_sel;
            tag_s1    <= '{valid: |rd_gnt, port_oh: rd_gnt};
            tag_s2    <= tag_s1;
            if (tag_s2.valid) rd_data_q <= ret_data;
        end
    end

`ifdef SRAM_ARB_WR_FWD_EN
    logic                  fwd_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    // The macro reads before it writes, so a same-cycle hit takes the write data instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= wr_en_q && rd_en_q && (wr_addr_q == rd_addr_q);
            fwd_data_q <= din_q;
        end
    end

    assign ret_data = fwd_q ? fwd_data_q : bus.sram_dout;
`else
    assign ret_data = bus.sram_dout;
`endif

    assign bus.wr_gnt       = wr_gnt;
    assign bus.rd_gnt       = rd_gnt;
    assign bus.rd_vld       = tag_s2.valid ? tag_s2.port_oh : '0;
    assign bus.rd_data      = tag_s2.valid ? ret_data : rd_data_q;
    assign bus.sram_wr_en   = wr_en_q;
    assign bus.sram_wr_addr = wr_addr_q;
    assign bus.sram_din     = din_q;
    assign bus.sram_rd_en   = rd_en_q;
    assign bus.sram_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model (build with SRAM_ARB_WR_FWD_EN for the forwarding variant).
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int NP = DEF_NUM_PORTS;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NP-1:0] wr_req, rd_req;
    logic [AW-1:0] wr_a [NP];
    logic [AW-1:0] rd_a [NP];
    logic [DW-1:0] wr_d [NP];

    always_comb begin
        bus.wr_req = wr_req;
        bus.rd_req = rd_req;
        for (int i = 0; i < NP; i++) begin
            bus.wr_addr[i*AW +: AW] = wr_a[i];
            bus.wr_data[i*DW +: DW] = wr_d[i];
            bus.rd_addr[i*AW +: AW] = rd_a[i];
        end
    end

    // SRAM macro: one-cycle read latency, read-before-write on a same-address collision.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    bit            sram_written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.sram_rd_en)
            bus.sram_dout <= sram_written[bus.sram_rd_addr] ? sram_mem[bus.sram_rd_addr] : '0;
        if (bus.sram_wr_en) begin
            sram_mem[bus.sram_wr_addr]     <= bus.sram_din;
            sram_written[bus.sram_wr_addr] <= 1'b1;
        end
    end

    // Reference model: transaction view of arbitration, memory contents and returns.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q [$];
    logic [DW-1:0] ref_mem [int];
    int            wptr, rptr, cyc, last_gw, last_gr;
    int            tests = 0;
    int            fails = 0;
    logic          exp_wr_en, exp_rd_en;
    logic [AW-1:0] exp_wr_addr, exp_rd_addr;
    logic [DW-1:0] exp_din, last_ret;

    function automatic logic [NP-1:0] onehot(int p);
        return (p < 0) ? '0 : (NP'(1) << p);
    endfunction

    function automatic int rr_pick(logic [NP-1:0] req, int ptr);
        for (int k = 0; k < NP; k++) begin
            int p = (ptr + k) % NP;
            if ((req & onehot(p)) != '0) return p;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        wptr = 0; rptr = 0;
        ret_q.delete();
        exp_wr_en = 1'b0; exp_rd_en = 1'b0;
        exp_wr_addr = '0; exp_rd_addr = '0; exp_din = '0;
        last_ret = '0; last_gw = -1; last_gr = -1;
    endtask

    task automatic clear_inputs();
        wr_req = '0;
        rd_req = '0;
    endtask

    // Check one cycle against the model, advance the model, then move to the next cycle.
    task automatic step();
        int   gw, gr;
        ret_t r;
        #1;
        gw = rr_pick(wr_req, wptr);
        gr = rr_pick(rd_req, rptr);
        check("wr_gnt", 32'(bus.wr_gnt), 32'(onehot(gw)));
        check("rd_gnt", 32'(bus.rd_gnt), 32'(onehot(gr)));
        check("sram_wr_en", 32'(bus.sram_wr_en), 32'(exp_wr_en));
        check("sram_rd_en", 32'(bus.sram_rd_en), 32'(exp_rd_en));
        if (exp_wr_en) begin
            check("sram_wr_addr", 32'(bus.sram_wr_addr), 32'(exp_wr_addr));
            check("sram_din", 32'(bus.sram_din), 32'(exp_din));
        end
        if (exp_rd_en) check("sram_rd_addr", 32'(bus.sram_rd_addr), 32'(exp_rd_addr));
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            check("rd_vld", 32'(bus.rd_vld), 32'(onehot(r.port)));
            check("rd_data", 32'(bus.rd_data), 32'(r.data));
            last_ret = r.data;
        end else begin
            check("rd_vld_idle", 32'(bus.rd_vld), 32'(0));
            check("rd_data_hold", 32'(bus.rd_data), 32'(last_ret));
        end
        exp_wr_en = (gw >= 0);
        exp_rd_en = (gr >= 0);
        if (gw >= 0) begin
            exp_wr_addr = wr_a[gw];
            exp_din     = wr_d[gw];
        end
        if (gr >= 0) begin
            exp_rd_addr = rd_a[gr];
            r.due  = cyc + 2;
            r.port = gr;
            r.data = ref_rd(rd_a[gr]);
`ifdef SRAM_ARB_WR_FWD_EN
            if (gw >= 0 && wr_a[gw] == rd_a[gr]) r.data = wr_d[gw];
`endif
            ret_q.push_back(r);
            rptr = (gr + 1) % NP;
        end
        if (gw >= 0) begin
            ref_mem[int'(wr_a[gw])] = wr_d[gw];
            wptr = (gw + 1) % NP;
        end
        last_gw = gw;
        last_gr = gr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] coll_exp;
        rst = 1'b1;
        cyc = 0;
        clear_inputs();
        for (int i = 0; i < NP; i++) begin
            wr_a[i] = '0; rd_a[i] = '0; wr_d[i] = '0;
        end
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sram_wr_en", 32'(bus.sram_wr_en), 32'(0));
        check("rst_sram_rd_en", 32'(bus.sram_rd_en), 32'(0));
        check("rst_sram_wr_addr", 32'(bus.sram_wr_addr), 32'(0));
        check("rst_sram_din", 32'(bus.sram_din), 32'(0));
        check("rst_rd_vld", 32'(bus.rd_vld), 32'(0));
        check("rst_rd_data", 32'(bus.rd_data), 32'(0));
        rst = 1'b0;

        // Round-robin fairness from reset: all ports hold a read for 8 cycles
        for (int i = 0; i < NP; i++) rd_a[i] = AW'(i);
        rd_req = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_fair_gnt", 32'(bus.rd_gnt), 32'(onehot(k % NP)));
            if (k >= 2) check("rr_fair_vld", 32'(bus.rd_vld), 32'(onehot((k - 2) % NP)));
            step();
        end
        rd_req = '0;
        repeat (3) step();

        // Single write then read on port 1
        wr_req = 4'b0010; wr_a[1] = 14'h0123; wr_d[1] = 16'hBEEF;
        step();
        wr_req = '0;
        step();
        rd_req = 4'b0010; rd_a[1] = 14'h0123;
        step();
        rd_req = '0;
        step();
        check("single_vld", 32'(bus.rd_vld), 32'(4'b0010));
        check("single_data", 32'(bus.rd_data), 32'(16'hBEEF));
        step();

        // Back-to-back reads from ports 0 and 2
        wr_req = 4'b0001; wr_a[0] = 14'h0010; wr_d[0] = 16'h1111;
        step();
        wr_req = 4'b0100; wr_a[2] = 14'h0020; wr_d[2] = 16'h2222;
        step();
        wr_req = '0;
        step();
        rd_req = 4'b0001; rd_a[0] = 14'h0010;
        step();
        rd_req = 4'b0100; rd_a[2] = 14'h0020;
        step();
        rd_req = '0;
        check("b2b_vld0", 32'(bus.rd_vld), 32'(4'b0001));
        check("b2b_data0", 32'(bus.rd_data), 32'(16'h1111));
        step();
        check("b2b_vld1", 32'(bus.rd_vld), 32'(4'b0100));
        check("b2b_data1", 32'(bus.rd_data), 32'(16'h2222));
        step();

        // Same-address collision at the top of the address space
        wr_req = 4'b0010; wr_a[1] = 14'h3FFF; wr_d[1] = 16'h0001;
        step();
        wr_req = '0;
        step();
        wr_req = 4'b0001; wr_a[0] = 14'h3FFF; wr_d[0] = 16'h00AA;
        rd_req = 4'b1000; rd_a[3] = 14'h3FFF;
        step();
        clear_inputs();
        step();
`ifdef SRAM_ARB_WR_FWD_EN
        coll_exp = 16'h00AA;
`else
        coll_exp = 16'h0001;
`endif
        check("coll_vld", 32'(bus.rd_vld), 32'(4'b1000));
        check("coll_data", 32'(bus.rd_data), 32'(coll_exp));
        rd_req = 4'b1000;
        step();
        rd_req = '0;
        step();
        check("coll_follow_vld", 32'(bus.rd_vld), 32'(4'b1000));
        check("coll_follow_data", 32'(bus.rd_data), 32'(16'h00AA));
        step();

        // Pointer hold: port 2 alone, then ports 0 and 3 together
        rd_req = 4'b0100; rd_a[2] = 14'h0020;
        repeat (3) step();
        rd_req = 4'b1001; rd_a[0] = 14'h0010; rd_a[3] = 14'h3FFF;
        #1;
        check("hold_first_gnt", 32'(bus.rd_gnt), 32'(4'b1000));
        step();
        rd_req = 4'b0001;
        #1;
        check("hold_second_gnt", 32'(bus.rd_gnt), 32'(4'b0001));
        step();
        rd_req = '0;
        repeat (3) step();

        // Reset one cycle after a read grant drops the in-flight return
        rd_req = 4'b0010; rd_a[1] = 14'h0123;
        step();
        rd_req = '0;
        rst = 1'b1;
        #1;
        check("rstmid_sram_rd_en", 32'(bus.sram_rd_en), 32'(0));
        check("rstmid_sram_rd_addr", 32'(bus.sram_rd_addr), 32'(0));
        check("rstmid_sram_wr_en", 32'(bus.sram_wr_en), 32'(0));
        check("rstmid_sram_din", 32'(bus.sram_din), 32'(0));
        check("rstmid_rd_vld", 32'(bus.rd_vld), 32'(0));
        @(posedge clk);
        #1;
        check("rstmid_rd_vld_late", 32'(bus.rd_vld), 32'(0));
        rst = 1'b0;
        model_reset();
        repeat (2) step();
        rd_req = '1; wr_req = '1;
        for (int i = 0; i < NP; i++) begin
            wr_a[i] = AW'(i + 8); wr_d[i] = DW'(16'h5000 + i);
        end
        #1;
        check("rstmid_rd_gnt0", 32'(bus.rd_gnt), 32'(4'b0001));
        check("rstmid_wr_gnt0", 32'(bus.wr_gnt), 32'(4'b0001));
        step();
        clear_inputs();
        repeat (3) step();

        // Random traffic on a small address window so collisions are frequent
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!wr_req[p] || p == last_gw) begin
                    wr_req[p] = 1'($urandom_range(1));
                    wr_a[p]   = AW'($urandom_range(7));
                    wr_d[p]   = DW'($urandom);
                end else if ($urandom_range(7) == 0) begin
                    wr_req[p] = 1'b0;
                end
                if (!rd_req[p] || p == last_gr) begin
                    rd_req[p] = 1'($urandom_range(1));
                    rd_a[p]   = AW'($urandom_range(7));
                end else if ($urandom_range(7) == 0) begin
                    rd_req[p] = 1'b0;
                end
            end
            step();
        end
        clear_inputs();
        repeat (3) step();
        check("drain_empty", 32'(ret_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port-write / single-port-read packet-buffer SRAM (14-bit address, 16-bit data) between NUM_PORTS requesters.
- Contains independent round-robin arbitration for the write channel and the read channel.
- Registers the SRAM command, tracks in-flight reads, and returns read data tagged one-hot to the requester.
- Sits between the port ingress/egress logic and the SRAM macro.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_WIDTH, 14, SRAM address width
DATA_WIDTH, 16, SRAM word width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_req  in  NUM_PORTS  per-port write request, held until granted
wr_addr  in  NUM_PORTS*ADDR_WIDTH  packed write addresses, port i at [i*AW +: AW]
wr_data  in  NUM_PORTS*DATA_WIDTH  packed write data
wr_gnt  out  NUM_PORTS  one-hot write grant, combinational, same cycle as accept
rd_req  in  NUM_PORTS  per-port read request, held until granted
rd_addr  in  NUM_PORTS*ADDR_WIDTH  packed read addresses
rd_gnt  out  NUM_PORTS  one-hot read grant, combinational
rd_vld  out  NUM_PORTS  one-hot read-return strobe
rd_data  out  DATA_WIDTH  read-return data, valid while any rd_vld bit is set
sram_wr_en  out  1  SRAM write enable (registered)
sram_wr_addr  out  ADDR_WIDTH  SRAM write address (registered)
sram_din  out  DATA_WIDTH  SRAM write data (registered)
sram_rd_en  out  1  SRAM read enable (registered)
sram_rd_addr  out  ADDR_WIDTH  SRAM read address (registered)
sram_dout  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_rd_en is sampled

Behaviour:
- Reset (asynchronous):
  - All registered outputs go to 0.
  - Both round-robin pointers go to 0.
  - The read-tag pipeline clears.
  - In-flight reads are dropped: no rd_vld is ever issued for a read accepted before reset.
- Arbitration, per channel, independent:
  - The grant goes to the first requesting port at or after the pointer, modulo NUM_PORTS.
  - At most one grant per channel per cycle.
  - A grant in cycle T means the request is accepted at the T/T+1 edge.
  - After a grant to port g, the pointer becomes (g+1) mod NUM_PORTS.
  - With no request, the pointer holds.
  - Starvation bound: a held request is granted within NUM_PORTS cycles.
- Handshake:
  - The requester keeps req, addr and data stable until it sees its gnt high.
  - It may deassert req or change address in the cycle after the grant.
  - A request dropped before its grant is legal and simply not serviced.
- Write timing:
  - Grant in cycle T; sram_wr_en, addr and din are high/valid in T+1.
  - The SRAM writes at the end of T+1.
- Read timing:
  - Grant in cycle T; sram_rd_en and addr are valid in T+1; sram_dout is valid in T+2.
  - In T+2, rd_vld[g]=1 and rd_data=sram_dout.
  - Fixed latency of 2 cycles from grant to data.
  - Fully pipelined: one read per cycle sustained, returns in grant order.
- Tag pipeline:
  - Two stages of one-hot port ID plus valid.
  - Outside a return cycle, rd_vld=0 and rd_data holds its last value.
- Same-cycle events:
  - A write grant and a read grant in the same cycle are both issued.
  - A read of the same address as the simultaneous write returns the old contents (SRAM read-before-write), unless the optional feature is enabled.
  - A read issued in the cycle after a write to the same address returns the new data.
- The same port may hold a write grant and a read grant in the same cycle.

Optional Feature:
- Macro: SRAM_ARB_WR_FWD_EN.
- Enabled:
  - A comparator registers a forward flag and the write data when sram_wr_en && sram_rd_en && sram_wr_addr==sram_rd_addr.
  - In the return cycle rd_data takes the forwarded write data instead of sram_dout, giving read-after-write-same-cycle semantics.
- Disabled: no comparator; rd_data=sram_dout always.

Decomposition:
- Package sram_arb_pkg: default NUM_PORTS/ADDR_WIDTH/DATA_WIDTH localparams, port-ID width, and a typedef for the read-tag pipeline entry (valid, one-hot port).
- Sub-module rr_arbiter (parameter N: req in, one-hot gnt out, internal pointer, clk/rst), instantiated once for the write channel and once for the read channel.

Test Plan:
- Single write then read: port 1 writes 0xBEEF to addr 0x0123; port 1 reads addr 0x0123 two cycles later -> rd_vld=4'b0010, rd_data=0xBEEF exactly 2 cycles after rd_gnt.
- Round-robin fairness: all 4 ports hold rd_req for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; rd_vld sequence matches, delayed 2 cycles.
- Back-to-back pipeline: ports 0 and 2 read addrs 0x10 and 0x20 (preloaded 0x1111 and 0x2222) in consecutive cycles -> returns 0x1111 on port 0 then 0x2222 on port 2 in consecutive cycles.
- Same-address collision: preload addr 0x3FFF=0x0001; in one cycle port 0 writes 0x00AA there and port 3 reads it -> rd_data=0x0001 without the macro, 0x00AA with SRAM_ARB_WR_FWD_EN; a follow-up read returns 0x00AA in both builds.
- Reset mid-read: assert rst one cycle after a read grant -> no rd_vld afterwards, all sram_* outputs 0, next grant starts from port 0.
- Pointer hold: only port 2 requests for 3 cycles, then ports 0 and 3 request together -> port 3 is granted first (pointer=3), then port 0.
